// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: FSM state encoding, line
// geometry, and helpers that split an address into line tag and base.
package arb_types;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int ADDR_BITS        = 32;
    localparam int TAG_BITS         = ADDR_BITS - LINE_OFFSET_BITS;

    typedef logic [255:0]         line_t;
    typedef logic [TAG_BITS-1:0]  tag_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SERVE_I = 3'd1,
        SERVE_D = 3'd2,
        SERVE_P = 3'd3,
        BUF_HIT = 3'd4
    } arb_state_e;

    // Line tag of a byte address (drops the offset within the 32-byte line).
    function automatic tag_t line_tag(input logic [ADDR_BITS-1:0] addr);
        line_tag = tag_t'(addr >> LINE_OFFSET_BITS);
    endfunction

    // Line-aligned byte address rebuilt from a tag.
    function automatic logic [ADDR_BITS-1:0] line_base(input tag_t tag);
        line_base = {tag, {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the arbiter, its three requesters and physical memory.
// slave = arbiter side, master = requester/memory side.
interface cache_mem_arbiter_if;
    import arb_types::*;

    logic        icache_read;
    logic [31:0] icache_addr;
    line_t       icache_rdata;
    logic        icache_resp;

    logic        dcache_read;
    logic        dcache_write;
    logic [31:0] dcache_addr;
    line_t       dcache_wdata;
    line_t       dcache_rdata;
    logic        dcache_resp;

    logic        prefetch_mem_read;
    logic [31:0] prefetch_mem_addr;
    line_t       prefetch_mem_data;
    logic        prefetch_mem_resp;
    logic        prefetch_enable;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_addr;
    line_t       pmem_wdata;
    line_t       pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  icache_read, icache_addr,
        input  dcache_read, dcache_write, dcache_addr, dcache_wdata,
        input  prefetch_mem_read, prefetch_mem_addr,
        input  pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp,
        output dcache_rdata, dcache_resp,
        output prefetch_mem_data, prefetch_mem_resp, prefetch_enable,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output icache_read, icache_addr,
        output dcache_read, dcache_write, dcache_addr, dcache_wdata,
        output prefetch_mem_read, prefetch_mem_addr,
        output pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp,
        input  dcache_rdata, dcache_resp,
        input  prefetch_mem_data, prefetch_mem_resp, prefetch_enable,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

endinterface

// File: rtl/cache_mem_arbiter_prefetch_line_buf.sv
// Single-line prefetch buffer: holds the last prefetched line, answers a
// tag lookup, and drops the line when a write to the same line completes.
// With EN=0 the valid bit never sets, so the buffer never hits.
module prefetch_line_buf
    import arb_types::*;
#(
    parameter bit EN = 1'b1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  fill_i,
    input  tag_t  fill_tag_i,
    input  line_t fill_data_i,
    input  logic  inv_i,
    input  tag_t  inv_tag_i,
    input  tag_t  lookup_tag_i,
    output logic  hit_o,
    output line_t data_o
);

    logic  valid_q;
    tag_t  tag_q;
    line_t data_q;

    // Fill on prefetch completion; a later fill replaces the line outright.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (fill_i && EN) begin
            valid_q <= 1'b1;
            tag_q   <= fill_tag_i;
            data_q  <= fill_data_i;
        end else if (inv_i && valid_q && (tag_q == inv_tag_i)) begin
            valid_q <= 1'b0;
        end
    end

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbiter granting one of icache, dcache or prefetcher access to physical
// memory, one transaction at a time with no preemption. icache/dcache
// conflicts alternate via last_d; prefetch only runs when both caches idle.
// Optional feature macro: PREFETCH_BUF_EN adds a one-line prefetch buffer
// that can answer icache reads without touching memory.
module cache_mem_arbiter
    import arb_types::*;
(
    input logic                clk,
    input logic                rst,
    cache_mem_arbiter_if.slave bus
);

`ifdef PREFETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    arb_state_e  state_q;
    arb_state_e  grant_d;
    logic        last_d_q;
    logic        pmem_read_q;
    logic        pmem_write_q;
    logic [31:0] pmem_addr_q;

    logic        d_req_s;
    logic        buf_hit_s;
    line_t       buf_data_s;
    logic        buf_fill_s;
    logic        buf_inv_s;

    assign d_req_s = bus.dcache_read || bus.dcache_write;

    // Memory-side completion events that update the prefetch buffer.
    assign buf_fill_s = (state_q == SERVE_P) && bus.pmem_resp;
    assign buf_inv_s  = (state_q == SERVE_D) && bus.pmem_resp && pmem_write_q;

    prefetch_line_buf #(
        .EN (BUF_EN)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .fill_i       (buf_fill_s),
        .fill_tag_i   (line_tag(pmem_addr_q)),
        .fill_data_i  (bus.pmem_rdata),
        .inv_i        (buf_inv_s),
        .inv_tag_i    (line_tag(pmem_addr_q)),
        .lookup_tag_i (line_tag(bus.icache_addr)),
        .hit_o        (buf_hit_s),
        .data_o       (buf_data_s)
    );

    // Grant choice made in IDLE: buffer hit, then fair icache/dcache, then prefetch.
    always_comb begin
        grant_d = IDLE;
        if (bus.icache_read && buf_hit_s) begin
            grant_d = BUF_HIT;
        end else if (d_req_s && !(bus.icache_read && last_d_q)) begin
            grant_d = SERVE_D;
        end else if (bus.icache_read) begin
            grant_d = SERVE_I;
        end else if (bus.prefetch_mem_read) begin
            grant_d = SERVE_P;
        end else begin
            grant_d = IDLE;
        end
    end

    // Arbiter FSM; memory command and line address are latched at grant so a
    // requester that drops mid-transaction still sees the access finish.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_d_q     <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= grant_d;
                    case (grant_d)
                        SERVE_I: begin
                            last_d_q     <= 1'b0;
                            pmem_read_q  <= 1'b1;
                            pmem_write_q <= 1'b0;
                            pmem_addr_q  <= line_base(line_tag(bus.icache_addr));
                        end
                        SERVE_D: begin
                            last_d_q     <= 1'b1;
                            pmem_read_q  <= !bus.dcache_write;
                            pmem_write_q <= bus.dcache_write;
                            pmem_addr_q  <= line_base(line_tag(bus.dcache_addr));
                        end
                        SERVE_P: begin
                            pmem_read_q  <= 1'b1;
                            pmem_write_q <= 1'b0;
                            pmem_addr_q  <= line_base(line_tag(bus.prefetch_mem_addr));
                        end
                        default: begin
                            pmem_read_q  <= 1'b0;
                            pmem_write_q <= 1'b0;
                            pmem_addr_q  <= 32'd0;
                        end
                    endcase
                end
                SERVE_I, SERVE_D, SERVE_P: begin
                    if (bus.pmem_resp) begin
                        state_q      <= IDLE;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        pmem_addr_q  <= 32'd0;
                    end
                end
                BUF_HIT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q      <= IDLE;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                    pmem_addr_q  <= 32'd0;
                end
            endcase
        end
    end

    assign bus.pmem_read  = pmem_read_q;
    assign bus.pmem_write = pmem_write_q;
    assign bus.pmem_addr  = pmem_addr_q;

    // Route memory response to the granted requester only, in the same cycle.
    always_comb begin
        bus.icache_resp       = 1'b0;
        bus.icache_rdata      = 256'd0;
        bus.dcache_resp       = 1'b0;
        bus.dcache_rdata      = 256'd0;
        bus.prefetch_mem_resp = 1'b0;
        bus.prefetch_mem_data = 256'd0;
        bus.prefetch_enable   = 1'b0;
        bus.pmem_wdata        = 256'd0;
        case (state_q)
            IDLE: begin
                bus.prefetch_enable = rst && !bus.icache_read && !d_req_s;
            end
            SERVE_I: begin
                if (bus.pmem_resp && bus.icache_read) begin
                    bus.icache_resp  = 1'b1;
                    bus.icache_rdata = bus.pmem_rdata;
                end else begin
                    bus.icache_resp  = 1'b0;
                    bus.icache_rdata = 256'd0;
                end
            end
            SERVE_D: begin
                bus.pmem_wdata = bus.dcache_wdata;
                if (bus.pmem_resp && d_req_s) begin
                    bus.dcache_resp  = 1'b1;
                    bus.dcache_rdata = bus.pmem_rdata;
                end else begin
                    bus.dcache_resp  = 1'b0;
                    bus.dcache_rdata = 256'd0;
                end
            end
            SERVE_P: begin
                if (bus.pmem_resp && bus.prefetch_mem_read) begin
                    bus.prefetch_mem_resp = 1'b1;
                    bus.prefetch_mem_data = bus.pmem_rdata;
                end else begin
                    bus.prefetch_mem_resp = 1'b0;
                    bus.prefetch_mem_data = 256'd0;
                end
            end
            BUF_HIT: begin
                bus.icache_resp  = 1'b1;
                bus.icache_rdata = buf_data_s;
            end
            default: begin
                bus.icache_resp = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter. Inputs change on the falling edge,
// outputs are sampled on the falling edge or 1 time unit after it.
module tb_cache_mem_arbiter;
    import arb_types::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic clear_inputs;
        bus.icache_read       = 1'b0;
        bus.icache_addr       = 32'd0;
        bus.dcache_read       = 1'b0;
        bus.dcache_write      = 1'b0;
        bus.dcache_addr       = 32'd0;
        bus.dcache_wdata      = 256'd0;
        bus.prefetch_mem_read = 1'b0;
        bus.prefetch_mem_addr = 32'd0;
        bus.pmem_rdata        = 256'd0;
        bus.pmem_resp         = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.icache_resp, bus.dcache_resp,
             bus.prefetch_mem_resp, bus.prefetch_enable} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000", {bus.pmem_read, bus.pmem_write,
                     bus.icache_resp, bus.dcache_resp, bus.prefetch_mem_resp, bus.prefetch_enable});
        end
        checks++;
        if (bus.pmem_addr !== 32'd0) begin
            errors++; $display("FAIL reset_addr got=%h exp=0", bus.pmem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.prefetch_enable !== 1'b1) begin
            errors++; $display("FAIL idle_prefetch_enable got=%b exp=1", bus.prefetch_enable);
        end
    endtask

    task automatic test_icache_read;
        line_t d;
        d = {8{32'h1111_2222}};
        @(negedge clk);
        bus.icache_read = 1'b1; bus.icache_addr = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h100) begin
            errors++; $display("FAIL icache_issue got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=100",
                               bus.pmem_read, bus.pmem_write, bus.pmem_addr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.icache_resp !== 1'b0) begin
            errors++; $display("FAIL icache_wait got rd=%b resp=%b exp rd=1 resp=0",
                               bus.pmem_read, bus.icache_resp);
        end
        bus.pmem_resp = 1'b1; bus.pmem_rdata = d;
        #1;
        checks++;
        if (bus.icache_resp !== 1'b1 || bus.icache_rdata !== d || bus.dcache_resp !== 1'b0) begin
            errors++; $display("FAIL icache_resp got resp=%b data=%h exp resp=1 data=%h",
                               bus.icache_resp, bus.icache_rdata, d);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.icache_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.icache_rdata !== 256'd0) begin
            errors++; $display("FAIL icache_one_cycle got resp=%b rd=%b exp resp=0 rd=0",
                               bus.icache_resp, bus.pmem_read);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_arbitration;
        line_t w;
        line_t r;
        w = {8{32'hDEAD_BEEF}};
        r = {8{32'h0BAD_F00D}};
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.icache_read = 1'b1; bus.icache_addr = 32'h100;
        bus.dcache_write = 1'b1; bus.dcache_addr = 32'h200; bus.dcache_wdata = w;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (k != 1) begin
                if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_addr !== 32'h200 ||
                    bus.pmem_wdata !== w) begin
                    errors++; $display("FAIL arb_d_grant%0d got wr=%b rd=%b addr=%h exp wr=1 rd=0 addr=200",
                                       k, bus.pmem_write, bus.pmem_read, bus.pmem_addr);
                end
            end else begin
                if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h100) begin
                    errors++; $display("FAIL arb_i_grant got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=100",
                                       bus.pmem_read, bus.pmem_write, bus.pmem_addr);
                end
            end
            bus.pmem_resp = 1'b1; bus.pmem_rdata = r;
            #1;
            checks++;
            if ({bus.icache_resp, bus.dcache_resp} !== ((k == 1) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL arb_resp%0d got i=%b d=%b exp i=%b d=%b", k,
                                   bus.icache_resp, bus.dcache_resp, (k == 1), (k != 1));
            end
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            checks++;
            if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.prefetch_enable !== 1'b0) begin
                errors++; $display("FAIL arb_idle%0d got rd=%b wr=%b pe=%b exp 0 0 0", k,
                                   bus.pmem_read, bus.pmem_write, bus.prefetch_enable);
            end
        end
        clear_inputs();
    endtask

    task automatic test_dcache_ops;
        line_t d;
        line_t w;
        d = {8{32'h3333_4444}};
        w = {8{32'h5555_6666}};
        @(negedge clk);
        bus.dcache_read = 1'b1; bus.dcache_addr = 32'h345;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h340) begin
            errors++; $display("FAIL dread_issue got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=340",
                               bus.pmem_read, bus.pmem_write, bus.pmem_addr);
        end
        bus.pmem_resp = 1'b1; bus.pmem_rdata = d;
        #1;
        checks++;
        if (bus.dcache_resp !== 1'b1 || bus.dcache_rdata !== d || bus.icache_rdata !== 256'd0) begin
            errors++; $display("FAIL dread_resp got resp=%b data=%h exp resp=1 data=%h",
                               bus.dcache_resp, bus.dcache_rdata, d);
        end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        bus.dcache_write = 1'b1; bus.dcache_addr = 32'h3E0; bus.dcache_wdata = w;
        @(negedge clk);
        checks++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_wdata !== w) begin
            errors++; $display("FAIL drw_is_write got wr=%b rd=%b exp wr=1 rd=0",
                               bus.pmem_write, bus.pmem_read);
        end
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if (bus.dcache_resp !== 1'b1) begin
            errors++; $display("FAIL drw_resp got=%b exp=1", bus.dcache_resp);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_prefetch;
        line_t p;
        line_t q;
        p = {8{32'h7777_8888}};
        q = {8{32'h9999_AAAA}};
        @(negedge clk);
        bus.prefetch_mem_read = 1'b1; bus.prefetch_mem_addr = 32'h120;
        #1;
        checks++;
        if (bus.prefetch_enable !== 1'b1) begin
            errors++; $display("FAIL pf_enable got=%b exp=1", bus.prefetch_enable);
        end
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h120 || bus.prefetch_enable !== 1'b0) begin
            errors++; $display("FAIL pf_issue got rd=%b addr=%h pe=%b exp rd=1 addr=120 pe=0",
                               bus.pmem_read, bus.pmem_addr, bus.prefetch_enable);
        end
        bus.pmem_resp = 1'b1; bus.pmem_rdata = p;
        #1;
        checks++;
        if (bus.prefetch_mem_resp !== 1'b1 || bus.prefetch_mem_data !== p || bus.icache_resp !== 1'b0) begin
            errors++; $display("FAIL pf_resp got resp=%b data=%h exp resp=1 data=%h",
                               bus.prefetch_mem_resp, bus.prefetch_mem_data, p);
        end
        @(negedge clk);
        clear_inputs();
        bus.icache_read = 1'b1; bus.icache_addr = 32'h124;
        @(negedge clk);
`ifdef PREFETCH_BUF_EN
        checks++;
        if (bus.icache_resp !== 1'b1 || bus.icache_rdata !== p || bus.pmem_read !== 1'b0) begin
            errors++; $display("FAIL buf_hit got resp=%b rd=%b data=%h exp resp=1 rd=0 data=%h",
                               bus.icache_resp, bus.pmem_read, bus.icache_rdata, p);
        end
        @(negedge clk);
        checks++;
        if (bus.icache_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin
            errors++; $display("FAIL buf_hit_once got resp=%b rd=%b exp 0 0",
                               bus.icache_resp, bus.pmem_read);
        end
`else
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h120 || bus.icache_resp !== 1'b0) begin
            errors++; $display("FAIL nobuf_issue got rd=%b addr=%h resp=%b exp rd=1 addr=120 resp=0",
                               bus.pmem_read, bus.pmem_addr, bus.icache_resp);
        end
        bus.pmem_resp = 1'b1; bus.pmem_rdata = q;
        #1;
        checks++;
        if (bus.icache_resp !== 1'b1 || bus.icache_rdata !== q) begin
            errors++; $display("FAIL nobuf_resp got resp=%b data=%h exp resp=1 data=%h",
                               bus.icache_resp, bus.icache_rdata, q);
        end
        @(negedge clk);
`endif
        clear_inputs();
    endtask

    task automatic test_invalidate;
        line_t d;
        d = {8{32'hCCCC_DDDD}};
        @(negedge clk);
        bus.dcache_write = 1'b1; bus.dcache_addr = 32'h130; bus.dcache_wdata = d;
        @(negedge clk);
        checks++;
        if (bus.pmem_write !== 1'b1 || bus.pmem_addr !== 32'h120) begin
            errors++; $display("FAIL inv_write got wr=%b addr=%h exp wr=1 addr=120",
                               bus.pmem_write, bus.pmem_addr);
        end
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        clear_inputs();
        bus.icache_read = 1'b1; bus.icache_addr = 32'h120;
        @(negedge clk);
        checks++;
        if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h120 || bus.icache_resp !== 1'b0) begin
            errors++; $display("FAIL inv_refetch got rd=%b addr=%h resp=%b exp rd=1 addr=120 resp=0",
                               bus.pmem_read, bus.pmem_addr, bus.icache_resp);
        end
        bus.pmem_resp = 1'b1; bus.pmem_rdata = d;
        #1;
        checks++;
        if (bus.icache_resp !== 1'b1 || bus.icache_rdata !== d) begin
            errors++; $display("FAIL inv_resp got resp=%b data=%h exp resp=1 data=%h",
                               bus.icache_resp, bus.icache_rdata, d);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_inflight;
        @(negedge clk);
        bus.dcache_write = 1'b1; bus.dcache_addr = 32'h200;
        @(negedge clk);
        checks++;
        if (bus.pmem_write !== 1'b1) begin
            errors++; $display("FAIL rst_pre_write got=%b exp=1", bus.pmem_write);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.pmem_read, bus.pmem_write, bus.dcache_resp, bus.prefetch_enable} !== 4'b0 ||
            bus.pmem_addr !== 32'd0) begin
            errors++; $display("FAIL rst_abort got rd=%b wr=%b dresp=%b pe=%b addr=%h exp all 0",
                               bus.pmem_read, bus.pmem_write, bus.dcache_resp,
                               bus.prefetch_enable, bus.pmem_addr);
        end
        rst = 1'b1;
        bus.dcache_write = 1'b0;
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if (bus.dcache_resp !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
            errors++; $display("FAIL rst_late_resp got dresp=%b rd=%b wr=%b exp 0 0 0",
                               bus.dcache_resp, bus.pmem_read, bus.pmem_write);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0 || bus.dcache_resp !== 1'b0) begin
            errors++; $display("FAIL rst_stay_idle got rd=%b wr=%b dresp=%b exp 0 0 0",
                               bus.pmem_read, bus.pmem_write, bus.dcache_resp);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_prefetch_starved;
        int served;
        served = 0;
        @(negedge clk);
        bus.icache_read = 1'b1; bus.icache_addr = 32'h200;
        bus.prefetch_mem_read = 1'b1; bus.prefetch_mem_addr = 32'h400;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.prefetch_enable !== 1'b0 || bus.prefetch_mem_resp !== 1'b0 ||
                bus.pmem_addr === 32'h400) begin
                errors++; $display("FAIL starve_cyc%0d got pe=%b presp=%b addr=%h exp pe=0 presp=0",
                                   i, bus.prefetch_enable, bus.prefetch_mem_resp, bus.pmem_addr);
            end
            if (bus.pmem_read === 1'b1) begin
                bus.pmem_resp = 1'b1;
                #1;
                if (bus.icache_resp === 1'b1) served++;
            end else begin
                bus.pmem_resp = 1'b0;
            end
        end
        checks++;
        if (served != 10) begin
            errors++; $display("FAIL starve_served got=%0d exp=10", served);
        end
        @(negedge clk);
        clear_inputs();
        bus.pmem_resp = 1'b1;
        #1;
        checks++;
        if (bus.icache_resp !== 1'b0 || bus.pmem_read !== 1'b1) begin
            errors++; $display("FAIL dropped_req got resp=%b rd=%b exp resp=0 rd=1",
                               bus.icache_resp, bus.pmem_read);
        end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1;
        checks++;
        if (bus.pmem_read !== 1'b0 || bus.prefetch_enable !== 1'b1) begin
            errors++; $display("FAIL dropped_done got rd=%b pe=%b exp rd=0 pe=1",
                               bus.pmem_read, bus.prefetch_enable);
        end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_arbitration();
        test_dcache_ops();
        test_prefetch();
        test_invalidate();
        test_reset_inflight();
        test_prefetch_starved();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset: synchronous, active-low (asserted when 0).
REQ-003 SHALL have ports icache_read in 1, icache_addr in 32, icache_rdata out 256, icache_resp out 1.
REQ-004 SHALL have ports dcache_read in 1, dcache_write in 1, dcache_addr in 32, dcache_wdata in 256, dcache_rdata out 256, dcache_resp out 1.
REQ-005 SHALL have ports prefetch_mem_read in 1, prefetch_mem_addr in 32, prefetch_mem_data out 256, prefetch_mem_resp out 1, prefetch_enable out 1.
REQ-006 SHALL have ports pmem_read out 1, pmem_write out 1, pmem_addr out 32, pmem_wdata out 256, pmem_rdata in 256, pmem_resp in 1.

Function
REQ-007 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, SERVE_P, BUF_HIT; one transaction at a time, no preemption.
REQ-008 SHALL in IDLE drive all pmem and resp outputs 0 and choose a grant registered into the next state.
REQ-009 SHALL, when icache and dcache both request in IDLE, grant the one not granted last (last_d flag, reset 0 = dcache first).
REQ-010 SHALL grant prefetch (SERVE_P) only when IDLE, prefetch_mem_read=1 and icache_read=dcache_read=dcache_write=0.
REQ-011 SHALL drive prefetch_enable=1 only in IDLE with no icache/dcache request.
REQ-012 SHALL in SERVE_x drive pmem_read/pmem_write from the granted request, pmem_addr = {addr[31:5],5'b0}, pmem_wdata = dcache_wdata.
REQ-013 SHALL route pmem_resp and pmem_rdata combinationally to the granted requester's resp/rdata in the same cycle, then return to IDLE.
REQ-014 SHALL hold non-granted resp outputs at 0 and rdata outputs at 0.
REQ-015 SHALL treat dcache_read and dcache_write both high as a write.
REQ-016 SHALL require requesters to hold request and address stable until their resp; requests dropped mid-transaction still complete on pmem without a resp pulse.
REQ-017 SHALL update last_d only on entry to SERVE_I or SERVE_D.

Reset
REQ-018 SHALL, while rst=0, force state IDLE, last_d=0, buffer valid=0; all outputs 0 on the following cycle.
REQ-019 SHALL abandon any in-flight transaction on reset; a pmem_resp arriving after reset in IDLE is ignored.

Configuration
REQ-020 SHALL honour macro PREFETCH_BUF_EN.
REQ-021 With PREFETCH_BUF_EN: one-line buffer (valid, tag = addr[31:5], 256-bit data), filled on SERVE_P completion.
REQ-022 With PREFETCH_BUF_EN: an IDLE icache_read whose addr[31:5] matches a valid tag SHALL enter BUF_HIT, assert icache_resp with buffer data the next cycle, issue no pmem access, and not change last_d.
REQ-023 With PREFETCH_BUF_EN: completion of SERVE_D write to a matching tag SHALL clear valid; a buffer hit outranks dcache in IDLE.
REQ-024 Without PREFETCH_BUF_EN: no buffer, no BUF_HIT state; prefetch data is forwarded only and icache always goes to pmem.

Structure
REQ-025 SHALL place the state enum, LINE_OFFSET_BITS=5 and the line-data typedef (256 bits) in shared package arb_types.
REQ-026 SHALL implement the prefetch buffer as sub-module prefetch_line_buf (tag compare, fill, invalidate).

Verification
REQ-027 icache_read @0x100 alone, pmem_resp after 4 cycles -> pmem_addr=0x100, icache_resp one cycle, rdata=pmem_rdata.
REQ-028 icache @0x100 and dcache write @0x200 same cycle after reset -> dcache served first, then icache; pmem_write then pmem_read.
REQ-029 prefetch_mem_read @0x120 with no cache traffic, then icache_read @0x124 (BUF_EN) -> one pmem read @0x120, icache_resp one cycle after request with prefetched data, no second pmem access.
REQ-030 BUF_EN: prefetch fill 0x120, dcache write 0x130, icache_read 0x120 -> buffer invalidated, icache goes to pmem @0x120.
REQ-031 rst=0 during SERVE_D awaiting resp, then pmem_resp=1 -> no dcache_resp, state IDLE, all outputs 0.
REQ-032 prefetch_mem_read held with continuous icache traffic -> prefetch_enable stays 0, SERVE_P never entered.
